// File: rtl/xgs_grab_trig_ctrl.sv
// Grab-trigger controller for the XGS sensor path: qualifies the selected trigger
// source, waits for sensor_ready and issues a single-cycle trigger to the sequencer.
module xgs_grab_trig_ctrl #(
    parameter int DEBOUNCE_W = 8,
    parameter int OVR_CNT_W  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  grab_cmd,
    input  logic [2:0]            grab_src,
    input  logic [2:0]            grab_act,
    input  logic                  grab_abort,
    input  logic                  hw_trig_in,
    input  logic                  sw_trig,
    input  logic                  sfnc_en,
    input  logic [DEBOUNCE_W-1:0] debounce_cfg,
    input  logic                  sensor_ready,
    output logic                  trig_out,
    output logic                  grab_pending,
    output logic                  cmd_err,
    output logic [OVR_CNT_W-1:0]  trig_overrun_cnt,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    localparam logic [2:0] SRC_IMM  = 3'd1;
    localparam logic [2:0] SRC_HW   = 3'd2;
    localparam logic [2:0] SRC_SW   = 3'd3;
    localparam logic [2:0] SRC_SFNC = 3'd4;

    localparam logic [2:0] ACT_RISE     = 3'd0;
    localparam logic [2:0] ACT_FALL     = 3'd1;
    localparam logic [2:0] ACT_ANY      = 3'd2;
    localparam logic [2:0] ACT_LEVEL_HI = 3'd3;
    localparam logic [2:0] ACT_LEVEL_LO = 3'd4;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [2:0]            src_q;
    logic [2:0]            act_q;
    logic                  hw_meta;
    logic                  hw_sync;
    logic                  hw_deb;
    logic                  hw_deb_q;
    logic [DEBOUNCE_W-1:0] deb_cnt;
    logic                  sfnc_q;

    logic hw_rise;
    logic hw_fall;
    logic hw_evt;
    logic hw_edge_evt;
    logic src_evt;
    logic ovr_evt;
    logic cmd_valid;
    logic accept;
    logic reject;
    logic fire;

    // Two-flop synchronizer followed by a stable-count debouncer.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            hw_meta  <= 1'b0;
            hw_sync  <= 1'b0;
            hw_deb   <= 1'b0;
            hw_deb_q <= 1'b0;
            deb_cnt  <= '0;
            sfnc_q   <= 1'b0;
        end else begin
            hw_meta  <= hw_trig_in;
            hw_sync  <= hw_meta;
            hw_deb_q <= hw_deb;
            sfnc_q   <= sfnc_en;
            if (hw_sync == hw_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == debounce_cfg) begin
                hw_deb  <= hw_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign hw_rise = hw_deb & ~hw_deb_q;
    assign hw_fall = ~hw_deb & hw_deb_q;

    always_comb begin
        hw_evt      = 1'b0;
        hw_edge_evt = 1'b0;
        case (act_q)
            ACT_RISE: begin
                hw_evt      = hw_rise;
                hw_edge_evt = hw_rise;
            end
            ACT_FALL: begin
                hw_evt      = hw_fall;
                hw_edge_evt = hw_fall;
            end
            ACT_ANY: begin
                hw_evt      = hw_rise | hw_fall;
                hw_edge_evt = hw_rise | hw_fall;
            end
            ACT_LEVEL_HI: hw_evt = hw_deb;
            ACT_LEVEL_LO: hw_evt = ~hw_deb;
            default: begin
                hw_evt      = 1'b0;
                hw_edge_evt = 1'b0;
            end
        endcase
    end

    // src_evt arms the trigger; ovr_evt is the edge-only flavour counted while waiting.
    always_comb begin
        src_evt = 1'b0;
        ovr_evt = 1'b0;
        case (src_q)
            SRC_HW: begin
                src_evt = hw_evt;
                ovr_evt = hw_edge_evt;
            end
            SRC_SW: begin
                src_evt = sw_trig;
                ovr_evt = sw_trig;
            end
            SRC_SFNC: begin
                src_evt = sfnc_en;
                ovr_evt = sfnc_en & ~sfnc_q;
            end
            default: begin
                src_evt = 1'b0;
                ovr_evt = 1'b0;
            end
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        case (grab_src)
            SRC_IMM, SRC_SW, SRC_SFNC: cmd_valid = 1'b1;
            SRC_HW:                    cmd_valid = (grab_act <= ACT_LEVEL_LO);
            default:                   cmd_valid = 1'b0;
        endcase
    end

    assign accept = grab_cmd && (state == ST_IDLE) && cmd_valid && !grab_abort;
    assign reject = grab_cmd && !accept;
    assign fire   = (state == ST_WAIT_RDY) && sensor_ready && !grab_abort;

    always_comb begin
        state_nxt = state;
        if (grab_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_nxt = (grab_src == SRC_IMM) ? ST_WAIT_RDY : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (src_evt) begin
                        state_nxt = ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (sensor_ready) begin
                        state_nxt = ((src_q == SRC_SFNC) && sfnc_en) ? ST_WAIT_RDY : ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state            <= ST_IDLE;
            src_q            <= 3'd0;
            act_q            <= 3'd0;
            trig_out         <= 1'b0;
            cmd_err          <= 1'b0;
            grab_pending     <= 1'b0;
            trig_overrun_cnt <= '0;
        end else begin
            state    <= state_nxt;
            trig_out <= fire;
            cmd_err  <= reject;
            // Pending stays high through the cycle the trigger pulse is issued.
            grab_pending <= (state_nxt != ST_IDLE) | fire;
            if (accept) begin
                src_q <= grab_src;
                act_q <= grab_act;
            end
            if ((state == ST_WAIT_RDY) && ovr_evt && !grab_abort &&
                (trig_overrun_cnt != {OVR_CNT_W{1'b1}})) begin
                trig_overrun_cnt <= trig_overrun_cnt + 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_xgs_grab_trig_ctrl.sv
// Directed bench for xgs_grab_trig_ctrl: hand-computed trigger cycles are queued
// and matched by a monitor; state and counters are checked inline.
module tb_xgs_grab_trig_ctrl;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    logic       sys_clk;
    logic       sys_reset;
    logic       grab_cmd;
    logic [2:0] grab_src;
    logic [2:0] grab_act;
    logic       grab_abort;
    logic       hw_trig_in;
    logic       sw_trig;
    logic       sfnc_en;
    logic [7:0] debounce_cfg;
    logic       sensor_ready;
    logic       trig_out;
    logic       grab_pending;
    logic       cmd_err;
    logic [3:0] trig_overrun_cnt;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    xgs_grab_trig_ctrl #(.DEBOUNCE_W(8), .OVR_CNT_W(4)) dut (
        .sys_clk          (sys_clk),
        .sys_reset        (sys_reset),
        .grab_cmd         (grab_cmd),
        .grab_src         (grab_src),
        .grab_act         (grab_act),
        .grab_abort       (grab_abort),
        .hw_trig_in       (hw_trig_in),
        .sw_trig          (sw_trig),
        .sfnc_en          (sfnc_en),
        .debounce_cfg     (debounce_cfg),
        .sensor_ready     (sensor_ready),
        .trig_out         (trig_out),
        .grab_pending     (grab_pending),
        .cmd_err          (cmd_err),
        .trig_overrun_cnt (trig_overrun_cnt),
        .state_dbg        (state_dbg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        sys_reset    = 1'b1;
        grab_cmd     = 1'b0;
        grab_src     = 3'd0;
        grab_act     = 3'd0;
        grab_abort   = 1'b0;
        hw_trig_in   = 1'b0;
        sw_trig      = 1'b0;
        sfnc_en      = 1'b0;
        sensor_ready = 1'b0;
        ticks(2);
        sys_reset = 1'b0;
        tick();
    endtask

    task automatic send_cmd(input logic [2:0] src, input logic [2:0] act);
        grab_cmd = 1'b1;
        grab_src = src;
        grab_act = act;
        tick();
        grab_cmd = 1'b0;
    endtask

    // Every trig_out pulse must match the next queued expected cycle.
    always @(negedge sys_clk) begin
        if (trig_out === 1'b1) begin
            if (exp_q.size() > 0) check("trig_cycle", 32'(cyc), exp_q.pop_front());
            else check("trig_unexpected", 32'(trig_out), 32'd0);
        end
    end

    initial begin
        int c;
        debounce_cfg = 8'd3;
        do_reset();
        check("rst_trig", 32'(trig_out), 0);
        check("rst_pending", 32'(grab_pending), 0);
        check("rst_cmd_err", 32'(cmd_err), 0);
        check("rst_ovr", 32'(trig_overrun_cnt), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // IMMEDIATE: cmd at c, WAIT_RDY at c+1, trig at c+2
        sensor_ready = 1'b1;
        c = cyc;
        exp_q.push_back(32'(c + 2));
        send_cmd(3'd1, 3'd0);
        check("imm_state_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        check("imm_pending_n1", 32'(grab_pending), 1);
        tick();
        check("imm_trig_n2", 32'(trig_out), 1);
        check("imm_pending_n2", 32'(grab_pending), 1);
        check("imm_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        check("imm_trig_n3", 32'(trig_out), 0);
        check("imm_pending_n3", 32'(grab_pending), 0);

        // HW_TRIG RISING, debounce_cfg=3
        send_cmd(3'd2, 3'd0);
        check("hw_armed", 32'(state_dbg), 32'(ST_ARMED));
        hw_trig_in = 1'b1;
        ticks(2);
        hw_trig_in = 1'b0;
        ticks(8);
        check("hw_glitch_armed", 32'(state_dbg), 32'(ST_ARMED));
        c = cyc;
        hw_trig_in = 1'b1;
        exp_q.push_back(32'(c + 8));
        ticks(6);
        check("hw_deb_cycle_armed", 32'(state_dbg), 32'(ST_ARMED));
        tick();
        check("hw_wait_c7", 32'(state_dbg), 32'(ST_WAIT_RDY));
        tick();
        check("hw_idle_c8", 32'(state_dbg), 32'(ST_IDLE));
        hw_trig_in = 1'b0;
        ticks(10);

        // HW_TRIG LEVEL_LO fires immediately while hw_deb=0
        c = cyc;
        exp_q.push_back(32'(c + 3));
        send_cmd(3'd2, 3'd4);
        check("lvl_armed", 32'(state_dbg), 32'(ST_ARMED));
        tick();
        check("lvl_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        ticks(2);
        check("lvl_ovr_none", 32'(trig_overrun_cnt), 0);

        // SW_TRIG overrun with sensor not ready
        do_reset();
        send_cmd(3'd3, 3'd0);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        check("sw_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        check("sw_ovr0", 32'(trig_overrun_cnt), 0);
        ticks(2);
        sw_trig = 1'b1;
        ticks(2);
        sw_trig = 1'b0;
        check("sw_ovr2", 32'(trig_overrun_cnt), 2);
        tick();
        check("sw_still_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        sensor_ready = 1'b1;
        c = cyc;
        exp_q.push_back(32'(c + 1));
        tick();
        sensor_ready = 1'b0;
        check("sw_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("sw_ovr_hold", 32'(trig_overrun_cnt), 2);
        tick();

        // SFNC continuous, ready 1,0,1 then sfnc_en drop
        do_reset();
        send_cmd(3'd4, 3'd0);
        sfnc_en = 1'b1;
        tick();
        check("sfnc_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        c = cyc;
        sensor_ready = 1'b1;
        exp_q.push_back(32'(c + 1));
        tick();
        sensor_ready = 1'b0;
        tick();
        sensor_ready = 1'b1;
        exp_q.push_back(32'(c + 3));
        tick();
        check("sfnc_stay_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        sensor_ready = 1'b0;
        sfnc_en = 1'b0;
        tick();
        check("sfnc_hold_wait", 32'(state_dbg), 32'(ST_WAIT_RDY));
        sensor_ready = 1'b1;
        exp_q.push_back(32'(c + 5));
        tick();
        sensor_ready = 1'b0;
        check("sfnc_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("sfnc_ovr", 32'(trig_overrun_cnt), 0);
        tick();

        // Command errors and abort
        send_cmd(3'd0, 3'd0);
        check("err_src0", 32'(cmd_err), 1);
        check("err_src0_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        check("err_clear", 32'(cmd_err), 0);
        send_cmd(3'd2, 3'd6);
        check("err_act6", 32'(cmd_err), 1);
        check("err_act6_pending", 32'(grab_pending), 0);
        send_cmd(3'd3, 3'd0);
        check("ok_cmd_err", 32'(cmd_err), 0);
        send_cmd(3'd1, 3'd0);
        check("err_armed", 32'(cmd_err), 1);
        check("err_armed_state", 32'(state_dbg), 32'(ST_ARMED));
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        check("latched_sw", 32'(state_dbg), 32'(ST_WAIT_RDY));
        grab_abort = 1'b1;
        tick();
        grab_abort = 1'b0;
        check("abort_wait", 32'(state_dbg), 32'(ST_IDLE));
        send_cmd(3'd3, 3'd0);
        grab_abort = 1'b1;
        sw_trig = 1'b1;
        tick();
        grab_abort = 1'b0;
        sw_trig = 1'b0;
        check("abort_sw_idle", 32'(state_dbg), 32'(ST_IDLE));
        ticks(2);
        send_cmd(3'd1, 3'd0);
        sensor_ready = 1'b1;
        grab_abort = 1'b1;
        tick();
        grab_abort = 1'b0;
        sensor_ready = 1'b0;
        check("abort_ready_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        check("abort_no_trig", 32'(trig_out), 0);

        // Overrun saturation on a 4-bit counter
        do_reset();
        send_cmd(3'd3, 3'd0);
        sw_trig = 1'b1;
        tick();
        ticks(10);
        check("sat_ovr10", 32'(trig_overrun_cnt), 10);
        ticks(10);
        sw_trig = 1'b0;
        check("sat_ovr15", 32'(trig_overrun_cnt), 15);
        tick();
        check("sat_pending", 32'(grab_pending), 1);

        // Asynchronous reset in WAIT_RDY
        sensor_ready = 1'b1;
        sys_reset = 1'b1;
        #1;
        check("arst_ovr", 32'(trig_overrun_cnt), 0);
        check("arst_pending", 32'(grab_pending), 0);
        check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        ticks(2);
        sys_reset = 1'b0;
        ticks(4);
        check("arst_trig", 32'(trig_out), 0);
        sensor_ready = 1'b0;
        tick();

        check("trig_q_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
